histo_readout: RTL

Downstream consumer of the photon demultiplexer/counter stage. On a start command it snapshots either the 8-bin per-channel histogram or the 64-bin inter-photon-interval histogram and serializes it as a framed, checksummed byte stream over a valid/ready interface toward the USB/serial TX FIFO. After a frame it can optionally request a histogram clear. It also reports whether a veto-window collision occurred since the previous frame.

---
 rtl/histo_readout_pkg.sv | 38 +++
 rtl/histo_readout_word_serializer.sv | 42 ++++
 rtl/histo_readout.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/histo_readout_pkg.sv
// Shared types and framing constants for the histogram readout block.
package histo_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } state_t;

  // Low two bits of the type byte identify which histogram is in the frame
  localparam logic [1:0] TYPE_HISTO = 2'b01;
  localparam logic [1:0] TYPE_IPI   = 2'b10;

  // Type-byte bit reporting a veto-window collision since the previous frame
  localparam int TYPE_FLAG_BIT = 7;

  // Frame layout: SYNC, type, N, 4*N data bytes, checksum
  localparam int HDR_BYTES       = 3;
  localparam int BYTES_PER_WORD  = 4;
  localparam int CSUM_BYTES      = 1;
  localparam int FRAME_LEN_HISTO = 36;
  localparam int FRAME_LEN_IPI   = 260;

  function automatic int frame_len(input int n_words);
    return HDR_BYTES + BYTES_PER_WORD * n_words + CSUM_BYTES;
  endfunction

  function automatic logic [7:0] make_type_byte(input logic flag, input logic ipi);
    logic [7:0] b;
    b                = '0;
    b[1:0]           = ipi ? TYPE_IPI : TYPE_HISTO;
    b[TYPE_FLAG_BIT] = flag;
    return b;
  endfunction

endpackage

// File: rtl/histo_readout_word_serializer.sv
// Splits a 32-bit word into four bytes, least significant first, under a
// valid/ready handshake. A load always restarts the sequence at byte 0 and
// takes priority over a simultaneous byte consumption.
module word_serializer (
  input  logic        read_clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        byte_last
);

  logic [31:0] shift_reg;
  logic [1:0]  cnt_reg;
  logic        valid_reg;

  // Shift register advancing one byte per consumed byte
  always_ff @(posedge read_clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= word_in;
      cnt_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (valid_reg && byte_ready) begin
      shift_reg <= {8'h00, shift_reg[31:8]};
      cnt_reg   <= cnt_reg + 2'd1;
      if (cnt_reg == 2'd3) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign byte_data  = shift_reg[7:0];
  assign byte_valid = valid_reg;
  assign byte_last  = valid_reg && (cnt_reg == 2'd3);

endmodule

// File: rtl/histo_readout.sv
// Snapshots one of the two histograms on a start command and streams it out
// as a framed, XOR-checksummed byte sequence over valid/ready. Every output
// is a flop; tx_ready only steers which value is loaded next.
module histo_readout
  import histo_readout_pkg::*;
#(
  parameter int         NHISTO = 8,
  parameter int         NIPI   = 64,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic                 read_clk,
  input  logic                 rst_n,
  input  logic [NHISTO*32-1:0] histo,
  input  logic [NIPI*32-1:0]   ipihist,
  input  logic                 collision,
  input  logic                 start,
  input  logic                 sel_ipi,
  input  logic                 clear_after,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 resethist_req,
  output logic [15:0]          frames_sent
);

  // One extra bit so the index can reach the word count itself
  localparam int WIDX_W = $clog2(NIPI) + 1;

  state_t             state_reg, state_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic               tx_valid_reg, tx_valid_next;
  logic [1:0]         hdr_idx_reg, hdr_idx_next;
  logic [WIDX_W-1:0]  word_idx_reg, word_idx_next;
  logic [7:0]         csum_reg, csum_next;
  logic               busy_reg;
  logic               resethist_req_reg;
  logic [15:0]        frames_sent_reg;
  logic               sel_ipi_reg;
  logic               clear_after_reg;
  logic               flag_reg;
  logic               coll_sticky_reg;

  logic               snap_en;
  logic               accept;
  logic               frame_done;
  logic [WIDX_W-1:0]  n_words;

  logic [NIPI-1:0][31:0] snap_in;
  logic [31:0]           snap_mem [NIPI];

  logic        ser_load;
  logic        ser_ready;
  logic [31:0] ser_word;
  logic [7:0]  ser_byte;
  logic        ser_valid;
  logic        ser_last;

  assign snap_en = (state_reg == ST_IDLE) && start;
  assign accept  = tx_valid_reg && tx_ready;
  assign n_words = sel_ipi_reg ? WIDX_W'(NIPI) : WIDX_W'(NHISTO);

  // Per-word capture source: the low entries carry either histogram, the
  // rest only ever hold interval bins (stale in histo frames, never sent).
  genvar gi;
  generate
    for (gi = 0; gi < NIPI; gi++) begin : g_snap_src
      if (gi < NHISTO) begin : g_shared
        assign snap_in[gi] = sel_ipi ? ipihist[gi*32 +: 32] : histo[gi*32 +: 32];
      end else begin : g_ipi_only
        assign snap_in[gi] = ipihist[gi*32 +: 32];
      end
    end
  endgenerate

  // Snapshot the selected histogram on the start edge; frozen for the frame
  always_ff @(posedge read_clk) begin
    if (snap_en) begin
      for (int i = 0; i < NIPI; i++) begin
        snap_mem[i] <= snap_in[i];
      end
    end
  end

  assign ser_word = snap_mem[word_idx_reg[WIDX_W-2:0]];

  word_serializer u_ser (
    .read_clk   (read_clk),
    .rst_n      (rst_n),
    .load       (ser_load),
    .word_in    (ser_word),
    .byte_ready (ser_ready),
    .byte_data  (ser_byte),
    .byte_valid (ser_valid),
    .byte_last  (ser_last)
  );

  // Next-state and next-byte selection; tx_data_reg always holds the byte
  // on offer, and the following byte is prepared for the accepting edge.
  always_comb begin
    state_next    = state_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    hdr_idx_next  = hdr_idx_reg;
    word_idx_next = word_idx_reg;
    csum_next     = csum_reg;
    ser_load      = 1'b0;
    ser_ready     = 1'b0;
    frame_done    = 1'b0;

    if (accept) begin
      csum_next = csum_reg ^ tx_data_reg;
    end

    unique case (state_reg)
      ST_IDLE: begin
        tx_valid_next = 1'b0;
        if (start) begin
          state_next    = ST_HDR;
          tx_data_next  = SYNC;
          tx_valid_next = 1'b1;
          hdr_idx_next  = 2'd0;
          word_idx_next = '0;
          csum_next     = '0;
        end
      end

      ST_HDR: begin
        if (accept) begin
          unique case (hdr_idx_reg)
            2'd0: begin
              tx_data_next  = make_type_byte(flag_reg, sel_ipi_reg);
              ser_load      = 1'b1;
              word_idx_next = word_idx_reg + 1'b1;
              hdr_idx_next  = 2'd1;
            end
            2'd1: begin
              tx_data_next = 8'(n_words);
              hdr_idx_next = 2'd2;
            end
            default: begin
              tx_data_next = ser_byte;
              ser_ready    = 1'b1;
              state_next   = ST_DATA;
            end
          endcase
        end
      end

      ST_DATA: begin
        if (accept) begin
          if (ser_valid) begin
            tx_data_next = ser_byte;
            ser_ready    = 1'b1;
            if (ser_last && (word_idx_reg < n_words)) begin
              ser_load      = 1'b1;
              word_idx_next = word_idx_reg + 1'b1;
            end
          end else begin
            // Serializer drained: the byte just accepted was the last data byte
            tx_data_next = csum_next;
            state_next   = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        if (accept) begin
          tx_data_next  = '0;
          tx_valid_next = 1'b0;
          state_next    = ST_DONE;
          frame_done    = 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next    = ST_IDLE;
        tx_valid_next = 1'b0;
      end
    endcase
  end

  // Stream, status and frame-parameter registers; reset aborts any frame
  always_ff @(posedge read_clk) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      tx_data_reg       <= '0;
      tx_valid_reg      <= 1'b0;
      hdr_idx_reg       <= '0;
      word_idx_reg      <= '0;
      csum_reg          <= '0;
      busy_reg          <= 1'b0;
      resethist_req_reg <= 1'b0;
      frames_sent_reg   <= '0;
      sel_ipi_reg       <= 1'b0;
      clear_after_reg   <= 1'b0;
      flag_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      tx_data_reg       <= tx_data_next;
      tx_valid_reg      <= tx_valid_next;
      hdr_idx_reg       <= hdr_idx_next;
      word_idx_reg      <= word_idx_next;
      csum_reg          <= csum_next;
      busy_reg          <= (state_next != ST_IDLE);
      resethist_req_reg <= frame_done && clear_after_reg;
      frames_sent_reg   <= frames_sent_reg + 16'(frame_done);
      if (snap_en) begin
        sel_ipi_reg     <= sel_ipi;
        clear_after_reg <= clear_after;
        flag_reg        <= coll_sticky_reg | collision;
      end
    end
  end

  // Sticky collision flag; a collision on the snapshot edge counts for both
  // the frame being started and the next one
  always_ff @(posedge read_clk) begin
    if (!rst_n) begin
      coll_sticky_reg <= 1'b0;
    end else if (snap_en) begin
      coll_sticky_reg <= collision;
    end else if (collision) begin
      coll_sticky_reg <= 1'b1;
    end
  end

  assign tx_data       = tx_data_reg;
  assign tx_valid      = tx_valid_reg;
  assign busy          = busy_reg;
  assign resethist_req = resethist_req_reg;
  assign frames_sent   = frames_sent_reg;

endmodule
